// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller (stall/flush/freeze FSM)
// Optional perf counters stall_cnt/flush_cnt are enabled by HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pc_sel_branch,
  output logic [1:0]       state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   load_use;

  assign load_use = idex_memread && (idex_rd != 5'd0) &&
                    ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Reset forces the visible state to RUN immediately, not only after the edge.
  assign state = reset ? ST_RUN : state_q;

  always_comb begin
    state_d       = ST_RUN;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    pc_sel_branch = 1'b0;
    if (reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_d    = ST_WAIT;
    end else begin
      case (state_q)
        ST_RUN, ST_WAIT: begin
          if (branch_taken) begin
            pc_sel_branch = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            state_d       = ST_FLUSH;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
        ST_FLUSH: begin
          // The IF/ID instruction is being discarded, so its load-use match is ignored.
          if (branch_taken) begin
            pc_sel_branch = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            state_d       = ST_FLUSH;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if ((ifid_flush || idex_flush) && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  // Expected word: {state[1:0], pc_write, ifid_write, ifid_flush, idex_flush, pc_sel_branch}
  localparam logic [6:0] E_RUN  = 7'b00_11000;
  localparam logic [6:0] E_RUN2 = 7'b10_11000;
  localparam logic [6:0] E_RST  = 7'b00_11110;
  localparam logic [6:0] E_LU   = 7'b00_00010;
  localparam logic [6:0] E_LU2  = 7'b10_00010;
  localparam logic [6:0] E_BR0  = 7'b00_11111;
  localparam logic [6:0] E_BR1  = 7'b01_11111;
  localparam logic [6:0] E_BR2  = 7'b10_11111;
  localparam logic [6:0] E_FL   = 7'b01_11000;
  localparam logic [6:0] E_FRZ0 = 7'b00_00000;
  localparam logic [6:0] E_FRZ1 = 7'b01_00000;
  localparam logic [6:0] E_FRZ2 = 7'b10_00000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       idex_memread = 1'b0;
  logic [4:0] idex_rd = '0, ifid_rs1 = '0, ifid_rs2 = '0;
  logic       branch_taken = 1'b0, mem_busy = 1'b0;
  logic       pc_write, ifid_write, ifid_flush, idex_flush, pc_sel_branch;
  logic [1:0] state;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pc_sel_branch(pc_sel_branch), .state(state)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [6:0] exp;
    logic       rst;
  } sb_t;

  sb_t sb_q[$];
  int  n_total = 0;
  int  n_bad   = 0;
  int  m_stall = 0;
  int  m_flush = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                      input logic busy, input logic [6:0] exp);
    sb_t e;
    @(posedge clk);
    #1;
    reset = rst; idex_memread = mr; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2;
    branch_taken = br; mem_busy = busy;
    e.tag = tag; e.exp = exp; e.rst = rst;
    sb_q.push_back(e);
  endtask

  task automatic idle(input string tag, input logic [6:0] exp);
    step(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, exp);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, {25'd0, state, pc_write, ifid_write, ifid_flush, idex_flush, pc_sel_branch},
            {25'd0, e.exp});
`ifdef HAZARD_PERF_EN
      if (!e.rst) begin
        check({e.tag, "_stall_cnt"}, {28'd0, stall_cnt}, m_stall);
        check({e.tag, "_flush_cnt"}, {28'd0, flush_cnt}, m_flush);
        if (e.tag == "sat_release")
          check("stall_cnt_saturated", {28'd0, stall_cnt}, CNT_MAX);
      end
      if (e.rst) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (!e.exp[4] && m_stall < CNT_MAX) m_stall++;
        if ((e.exp[2] || e.exp[1]) && m_flush < CNT_MAX) m_flush++;
      end
`endif
    end
  end

  initial begin
    step("reset0", 1, 0, 0, 0, 0, 0, 0, E_RST);
    step("reset1", 1, 0, 0, 0, 0, 0, 0, E_RST);
    idle("run_idle", E_RUN);
    // load-use on rs2, then on rs1, and the x0 exemption
    step("lu_rs2",      0, 1, 5, 3, 5, 0, 0, E_LU);
    idle("lu_release",  E_RUN);
    step("rd_x0",       0, 1, 0, 0, 0, 0, 0, E_RUN);
    step("lu_rs1",      0, 1, 7, 7, 2, 0, 0, E_LU);
    step("no_memread",  0, 0, 7, 7, 7, 0, 0, E_RUN);
    // single branch; load-use in the FLUSH cycle is ignored
    step("br_run",      0, 0, 0, 0, 0, 1, 0, E_BR0);
    step("flush_lu",    0, 1, 5, 5, 0, 0, 0, E_FL);
    idle("after_flush", E_RUN);
    // back-to-back branches
    step("bb_br0",      0, 0, 0, 0, 0, 1, 0, E_BR0);
    step("bb_br1",      0, 0, 0, 0, 0, 1, 0, E_BR1);
    step("bb_br2",      0, 0, 0, 0, 0, 1, 0, E_BR1);
    idle("bb_end",      E_FL);
    idle("bb_run",      E_RUN);
    // mem_busy masks a pending branch, which fires on release
    step("busy_br0",    0, 1, 4, 4, 0, 1, 1, E_FRZ0);
    step("busy_br1",    0, 1, 4, 4, 0, 1, 1, E_FRZ2);
    step("busy_br2",    0, 1, 4, 4, 0, 1, 1, E_FRZ2);
    step("busy_rel_br", 0, 0, 0, 0, 0, 1, 0, E_BR2);
    idle("busy_fl",     E_FL);
    idle("busy_run",    E_RUN);
    // WAIT release evaluates load-use as RUN
    step("busy_lu0",    0, 1, 9, 0, 9, 0, 1, E_FRZ0);
    step("wait_lu",     0, 1, 9, 0, 9, 0, 0, E_LU2);
    idle("wait_lu_run", E_RUN);
    // busy during FLUSH
    step("fl_br",       0, 0, 0, 0, 0, 1, 0, E_BR0);
    step("fl_busy",     0, 0, 0, 0, 0, 1, 1, E_FRZ1);
    idle("fl_busy_rel", E_RUN2);
    // reset mid-WAIT with other inputs active
    step("rw_busy0",    0, 0, 0, 0, 0, 0, 1, E_FRZ0);
    step("rw_busy1",    0, 0, 0, 0, 0, 0, 1, E_FRZ2);
    step("rw_reset",    1, 1, 3, 3, 3, 1, 1, E_RST);
    idle("rw_after",    E_RUN);
    // reset mid-FLUSH
    step("rf_br",       0, 0, 0, 0, 0, 1, 0, E_BR0);
    step("rf_reset",    1, 0, 0, 0, 0, 1, 0, E_RST);
    idle("rf_after",    E_RUN);
    // 20 stall cycles to saturate a 4-bit counter
    step("sat_busy0",   0, 0, 0, 0, 0, 0, 1, E_FRZ0);
    for (int i = 1; i < 20; i++)
      step($sformatf("sat_busy%0d", i), 0, 0, 0, 0, 0, 0, 1, E_FRZ2);
    idle("sat_release", E_RUN2);
    idle("sat_run",     E_RUN);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, 32, width of the performance counters.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 idex_memread  in  1  instruction in the ID/EX register is a load.
REQ-005 idex_rd  in  5  destination register of the ID/EX instruction.
REQ-006 ifid_rs1, ifid_rs2  in  5 each  source registers of the IF/ID instruction.
REQ-007 branch_taken  in  1  EX stage resolved a taken branch this cycle.
REQ-008 mem_busy  in  1  data memory not ready; the pipeline must freeze.
REQ-009 pc_write, ifid_write  out  1 each  enables for the PC and IF/ID registers.
REQ-010 ifid_flush, idex_flush  out  1 each  flush requests for IF/ID and ID/EX; idex_flush drives the ID/EX flush input.
REQ-011 pc_sel_branch  out  1  PC loads the branch target this cycle.
REQ-012 state  out  2  current FSM state: RUN=0, FLUSH=1, WAIT=2.
REQ-013 stall_cnt, flush_cnt  out  CNT_W each  performance counters; present only with HAZARD_PERF_EN.

Function
REQ-014 The FSM SHALL have the states RUN, FLUSH and WAIT; state 3 is unreachable and SHALL go to RUN on the next edge.
REQ-015 Outputs SHALL be combinational from the state and inputs, with zero-cycle latency.
REQ-016 Priority SHALL be: reset > mem_busy > branch_taken > load-use.
REQ-017 A load-use hazard is defined as: idex_memread=1, idex_rd!=0, and idex_rd equals ifid_rs1 or ifid_rs2.
REQ-018 On a load-use hazard in RUN: pc_write=0, ifid_write=0, idex_flush=1, and the state SHALL stay RUN (one bubble).
REQ-019 On branch_taken in RUN or FLUSH: pc_sel_branch=1, ifid_flush=1, idex_flush=1, pc_write=1, and the next state SHALL be FLUSH.
REQ-020 In FLUSH without branch_taken: load-use detection SHALL be suppressed, all enables SHALL be 1, all flushes SHALL be 0, and the next state SHALL be RUN.
REQ-021 On mem_busy=1 in any state: pc_write=0, ifid_write=0, no flushes and pc_sel_branch=0; the next state SHALL be WAIT, and a pending branch or hazard SHALL not be acted on.
REQ-022 In WAIT with mem_busy=0: the outputs SHALL be evaluated as in RUN in the same cycle, and the next state SHALL follow the RUN rules.
REQ-023 With no hazard, branch or busy in RUN: pc_write=1, ifid_write=1, all flushes 0, pc_sel_branch 0.
REQ-024 Back-to-back taken branches SHALL each produce a flush, and the state SHALL remain FLUSH.

Reset
REQ-025 While reset=1: state=RUN, pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, pc_sel_branch=0, and the counters SHALL clear to 0.
REQ-026 A reset asserted during WAIT or FLUSH SHALL return the FSM to RUN on the next edge, regardless of the other inputs.

Configuration
REQ-027 Macro HAZARD_PERF_EN: when defined, stall_cnt SHALL increment each cycle that pc_write=0 and reset=0.
REQ-028 When defined, flush_cnt SHALL increment each cycle that ifid_flush or idex_flush is 1 and reset=0.
REQ-029 When defined, both counters SHALL saturate at 2^CNT_W-1.
REQ-030 When HAZARD_PERF_EN is undefined, the stall_cnt and flush_cnt ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 The bench SHALL cover load-use: idex_memread=1, idex_rd=5, ifid_rs2=5 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; next cycle (memread cleared) all enables=1.
REQ-032 The bench SHALL cover rd=x0: idex_memread=1, idex_rd=0, ifid_rs1=0 -> no stall, pc_write=1.
REQ-033 The bench SHALL cover a branch: branch_taken=1 for 1 cycle -> pc_sel_branch=1, both flushes=1, state FLUSH then RUN; a load-use match in the FLUSH cycle produces no stall.
REQ-034 The bench SHALL cover mem_busy with branch: mem_busy=1 for 3 cycles with branch_taken=1 -> 3 cycles frozen, no flush, state=WAIT; on release, a flush occurs in that cycle.
REQ-035 The bench SHALL cover reset mid-WAIT: reset=1 during WAIT -> state=RUN next edge; counters=0 (with HAZARD_PERF_EN).
REQ-036 The bench SHALL cover counters: with HAZARD_PERF_EN and CNT_W=4, 20 stall cycles -> stall_cnt=15 (saturated).
